// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file: default geometry,
// the hard-wired zero register index and the flattened-bus slicing helper.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // LSB of port k inside a flattened bus whose per-port field is width bits
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally
// maintained count of busy registers. Priority is flush, then issue, then writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        wra,
    input  logic                     issue,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_nxt_s;
    logic                set_s;
    logic                inc_s;
    logic                dec_s;

    // Next busy vector and count; a same-register issue overrides the retiring write
    always_comb begin
        set_s      = 1'b0;
        inc_s      = 1'b0;
        dec_s      = 1'b0;
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        if (issue) begin
            if ((ZERO_REG != 0) && (issue_reg == ADDR_W'(REG_ZERO))) begin
                set_s = 1'b0;
            end else begin
                set_s = 1'b1;
            end
        end else begin
            set_s = 1'b0;
        end
        inc_s = set_s & ~busy_r[issue_reg];
        dec_s = RegWrite & busy_r[wra] & ~(set_s & (issue_reg == wra));
        if (RegWrite) begin
            busy_nxt_s[wra] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (set_s) begin
            busy_nxt_s[issue_reg] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (flush) begin
            busy_nxt_s = {NUM_REGS{1'b0}};
            cnt_nxt_s  = {(ADDR_W+1){1'b0}};
        end else if (inc_s && !dec_s) begin
            cnt_nxt_s = cnt_r + (ADDR_W+1)'(1);
        end else if (dec_s && !inc_s) begin
            cnt_nxt_s = cnt_r - (ADDR_W+1)'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Busy state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_r <= {NUM_REGS{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD combinational read ports, optional zero
// register and write-to-read bypass, and an attached pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    RegWrite,
    input  logic [ADDR_W-1:0]       wra,
    input  logic [DATA_W-1:0]       wrd,
    input  logic [NREAD*ADDR_W-1:0] rreg,
    output logic [NREAD*DATA_W-1:0] rd,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    issue,
    input  logic [ADDR_W-1:0]       issue_reg,
    input  logic                    flush,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;
    logic                wr_en_s;

    // Storage write enable; writes to the zero register are dropped
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWrite) begin
            if ((ZERO_REG != 0) && (wra == ADDR_W'(REG_ZERO))) begin
                wr_en_s = 1'b0;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[wra] <= wrd;
        end else begin
            regs_r <= regs_r;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .nrst      (nrst),
        .RegWrite  (RegWrite),
        .wra       (wra),
        .issue     (issue),
        .issue_reg (issue_reg),
        .flush     (flush),
        .busy      (busy_s),
        .busy_cnt  (busy_cnt)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rdata_s;
        logic              hit_s;
        logic              rbusy_s;

        assign ra_s = rreg[port_lsb(k, ADDR_W) +: ADDR_W];

        // Read mux: zero register, then bypassed write data, then storage
        always_comb begin
            hit_s   = (BYPASS != 0) && RegWrite && (wra == ra_s);
            rdata_s = {DATA_W{1'b0}};
            if ((ZERO_REG != 0) && (ra_s == ADDR_W'(REG_ZERO))) begin
                rdata_s = {DATA_W{1'b0}};
            end else if (hit_s) begin
                rdata_s = wrd;
            end else begin
                rdata_s = regs_r[ra_s];
            end
            rbusy_s = busy_s[ra_s] & ~hit_s;
        end

        assign rd[port_lsb(k, DATA_W) +: DATA_W] = rdata_s;
        assign rbusy[k] = rbusy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an array-based reference model, over three parameter configurations.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus for the two 32x32 instances
    logic        we = 1'b0;
    logic [4:0]  wa = 5'd0;
    logic [31:0] wd = 32'd0;
    logic [4:0]  ra0 = 5'd0, ra1 = 5'd0;
    logic        iss = 1'b0;
    logic [4:0]  ir = 5'd0;
    logic        fl = 1'b0;
    logic [9:0]  rreg_s;
    assign rreg_s = {ra1, ra0};

    logic [63:0] rd_a, rd_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [5:0]  cnt_a, cnt_b;

    // 8x16, four read ports
    logic        q_we = 1'b0;
    logic [2:0]  q_wa = 3'd0;
    logic [15:0] q_wd = 16'd0;
    logic [11:0] q_rreg = 12'd0;
    logic [63:0] q_rd;
    logic [3:0]  q_rbusy;
    logic        q_iss = 1'b0;
    logic [2:0]  q_ir = 3'd0;
    logic        q_fl = 1'b0;
    logic [3:0]  q_cnt;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .nrst(nrst), .RegWrite(we), .wra(wa), .wrd(wd), .rreg(rreg_s),
        .rd(rd_a), .rbusy(rbusy_a), .issue(iss), .issue_reg(ir), .flush(fl), .busy_cnt(cnt_a));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .nrst(nrst), .RegWrite(we), .wra(wa), .wrd(wd), .rreg(rreg_s),
        .rd(rd_b), .rbusy(rbusy_b), .issue(iss), .issue_reg(ir), .flush(fl), .busy_cnt(cnt_b));

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) u_dut_q (
        .clk(clk), .nrst(nrst), .RegWrite(q_we), .wra(q_wa), .wrd(q_wd), .rreg(q_rreg),
        .rd(q_rd), .rbusy(q_rbusy), .issue(q_iss), .issue_reg(q_ir), .flush(q_fl), .busy_cnt(q_cnt));

    // reference model: index 0 = zero-reg+bypass instance, 1 = plain instance
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];
    bit          cfg_zero [2] = '{1'b1, 1'b0};
    bit          cfg_byp  [2] = '{1'b1, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[c][r] = 32'd0;
                m_busy[c][r] = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        if (cfg_zero[c] && a == 5'd0) return 32'd0;
        if (cfg_byp[c] && we && wa == a) return wd;
        return m_regs[c][a];
    endfunction

    function automatic logic exp_rbusy(input int c, input logic [4:0] a);
        return m_busy[c][a] && !(cfg_byp[c] && we && wa == a);
    endfunction

    function automatic int exp_cnt(input int c);
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[c][r]);
        return n;
    endfunction

    function automatic void model_tick();
        for (int c = 0; c < 2; c++) begin
            if (fl) begin
                for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
            end else begin
                if (we) m_busy[c][wa] = 1'b0;
                if (iss && !(cfg_zero[c] && ir == 5'd0)) m_busy[c][ir] = 1'b1;
            end
            if (we && !(cfg_zero[c] && wa == 5'd0)) m_regs[c][wa] = wd;
        end
    endfunction

    task automatic compare_model();
        logic [4:0] addr [2];
        addr[0] = ra0;
        addr[1] = ra1;
        for (int p = 0; p < 2; p++) begin
            check_val($sformatf("a_rd%0d", p), 64'(rd_a[p*32 +: 32]), 64'(exp_rd(0, addr[p])));
            check_val($sformatf("b_rd%0d", p), 64'(rd_b[p*32 +: 32]), 64'(exp_rd(1, addr[p])));
            check_val($sformatf("a_rbusy%0d", p), 64'(rbusy_a[p]), 64'(exp_rbusy(0, addr[p])));
            check_val($sformatf("b_rbusy%0d", p), 64'(rbusy_b[p]), 64'(exp_rbusy(1, addr[p])));
        end
        check_val("a_cnt", 64'(cnt_a), 64'(exp_cnt(0)));
        check_val("b_cnt", 64'(cnt_b), 64'(exp_cnt(1)));
    endtask

    // apply inputs after a falling edge and check the combinational view
    task automatic drive(input bit w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input bit is, input logic [4:0] ir_i, input bit f);
        @(negedge clk);
        we = w; wa = a; wd = d; ra0 = r0; ra1 = r1; iss = is; ir = ir_i; fl = f;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    initial begin
        model_reset();
        #23;
        @(negedge clk);
        nrst = 1'b1;

        drive(0, 5'd0, 32'd0, 5'd5, 5'd31, 0, 5'd0, 0); tick();

        // basic writes and reads
        drive(1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 5'd0, 0); tick();
        drive(1, 5'd31, 32'h12345678, 5'd0, 5'd0, 0, 5'd0, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd5, 5'd31, 0, 5'd0, 0);
        check_val("r5_const", 64'(rd_a[31:0]), 64'h00000000DEADBEEF);
        check_val("r31_const", 64'(rd_a[63:32]), 64'h0000000012345678);
        tick();

        // zero register ignores writes and issue
        drive(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 0, 5'd0, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd0, 0);
        check_val("r0_zero", 64'(rd_a[31:0]), 64'd0);
        check_val("b_r0_written", 64'(rd_b[31:0]), 64'h00000000FFFFFFFF);
        tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        check_val("r0_cnt", 64'(cnt_a), 64'd0);
        check_val("r0_rbusy", 64'(rbusy_a[0]), 64'd0);
        check_val("b_r0_busy", 64'(rbusy_b[0]), 64'd1);
        tick();
        drive(1, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0, 0); tick();

        // bypass of a write to a busy register
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd7, 0); tick();
        drive(1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0, 0, 5'd0, 0);
        check_val("byp_rd", 64'(rd_a[31:0]), 64'h00000000A5A5A5A5);
        check_val("byp_rbusy", 64'(rbusy_a[0]), 64'd0);
        check_val("nobyp_rd", 64'(rd_b[31:0]), 64'd0);
        check_val("nobyp_rbusy", 64'(rbusy_b[0]), 64'd1);
        tick();

        // scoreboard set/clear and same-register conflict
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd3, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd3, 5'd0, 0, 5'd0, 0);
        check_val("r3_busy", 64'(rbusy_a[0]), 64'd1);
        check_val("r3_cnt", 64'(cnt_a), 64'd1);
        tick();
        drive(1, 5'd3, 32'h33, 5'd0, 5'd0, 0, 5'd0, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd3, 5'd0, 0, 5'd0, 0);
        check_val("r3_clr", 64'(rbusy_a[0]), 64'd0);
        check_val("r3_cnt0", 64'(cnt_a), 64'd0);
        tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd4, 0); tick();
        drive(1, 5'd4, 32'h44, 5'd0, 5'd0, 1, 5'd4, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd4, 5'd0, 0, 5'd0, 0);
        check_val("r4_conflict", 64'(rbusy_a[0]), 64'd1);
        check_val("r4_cnt", 64'(cnt_a), 64'd1);
        tick();
        drive(1, 5'd4, 32'h45, 5'd0, 5'd0, 0, 5'd0, 0); tick();

        // flush beats a simultaneous issue
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd1, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd2, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd3, 0); tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0, 0);
        check_val("cnt3", 64'(cnt_a), 64'd3);
        tick();
        drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 1, 5'd9, 1); tick();
        drive(0, 5'd0, 32'd0, 5'd9, 5'd1, 0, 5'd0, 0);
        check_val("flush_cnt", 64'(cnt_a), 64'd0);
        check_val("flush_rbusy", 64'(rbusy_a), 64'd0);
        tick();

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a, r0, r1, irr;
            a   = 5'($urandom_range(0, 31));
            irr = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            r0  = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
            if (i == 200) begin
                @(negedge clk);
                we = 1'b0; iss = 1'b0; fl = 1'b0; ra0 = 5'd5; ra1 = 5'd31;
                nrst = 1'b0;
                #1;
                check_val("rst_rd_a", rd_a, 64'd0);
                check_val("rst_rd_b", rd_b, 64'd0);
                check_val("rst_cnt", 64'(cnt_a), 64'd0);
                check_val("rst_rbusy", 64'(rbusy_b), 64'd0);
                model_reset();
                @(negedge clk);
                nrst = 1'b1;
            end
            drive(bit'($urandom_range(0, 1)), a, $urandom, r0, r1,
                  bit'($urandom_range(0, 1)), irr, ($urandom_range(0, 15) == 0));
            tick();
        end

        @(negedge clk);
        we = 1'b0; iss = 1'b0; fl = 1'b0;

        // four-port instance: fill then read distinct and duplicate addresses
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q_we = 1'b1; q_wa = 3'(i); q_wd = 16'(i) * 16'h1111;
        end
        @(negedge clk);
        q_we = 1'b0;
        for (int t = 0; t < 12; t++) begin
            logic [2:0] qa [4];
            for (int p = 0; p < 4; p++) begin
                case (t)
                    0:       qa[p] = 3'(p);
                    1:       qa[p] = 3'(p + 4);
                    2:       qa[p] = 3'd6;
                    default: qa[p] = 3'($urandom_range(0, 7));
                endcase
            end
            @(negedge clk);
            q_rreg = {qa[3], qa[2], qa[1], qa[0]};
            #1;
            for (int p = 0; p < 4; p++) begin
                check_val($sformatf("q_rd%0d_t%0d", p, t), 64'(q_rd[p*16 +: 16]),
                          64'(16'(qa[p]) * 16'h1111));
            end
            check_val("q_rbusy", 64'(q_rbusy), 64'd0);
        end
        check_val("q_cnt", 64'(q_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
